// File: rtl/lcd_write_sequencer_pkg.sv
// Shared definitions for the HD44780-style 4-bit LCD write sequencer:
// FSM encoding, init/config command bytes and default timings (50 MHz clocks).
package lcd_write_sequencer_pkg;

  typedef enum logic [3:0] {
    POWERON, INIT_NIB, INIT_WAIT, CFG_HI, CFG_GAP, CFG_LO, CFG_WAIT,
    IDLE, DATA_HI, DATA_GAP, DATA_LO, DATA_WAIT
  } state_t;

  typedef enum logic [1:0] { PH_SETUP, PH_EN, PH_HOLD } phase_t;

  localparam logic [3:0] INIT_NIB_8BIT = 4'h3;
  localparam logic [3:0] INIT_NIB_4BIT = 4'h2;

  localparam logic [7:0] CMD_FUNCTION_SET = 8'h28;
  localparam logic [7:0] CMD_ENTRY_MODE   = 8'h06;
  localparam logic [7:0] CMD_DISPLAY_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR        = 8'h01;

  localparam int unsigned DEF_T_POWERON = 750000;
  localparam int unsigned DEF_T_4100US  = 205000;
  localparam int unsigned DEF_T_100US   = 5000;
  localparam int unsigned DEF_T_40US    = 2000;
  localparam int unsigned DEF_T_1640US  = 82000;
  localparam int unsigned DEF_T_GAP     = 50;
  localparam int unsigned DEF_T_SETUP   = 2;
  localparam int unsigned DEF_T_EN      = 12;
  localparam int unsigned DEF_T_HOLD    = 1;

  // Three 0x3 wake-up nibbles, then 0x2 switches the panel to 4-bit mode.
  function automatic logic [3:0] init_nibble(input logic [1:0] idx);
    return (idx == 2'd3) ? INIT_NIB_4BIT : INIT_NIB_8BIT;
  endfunction

  function automatic logic [7:0] cfg_command(input logic [1:0] idx);
    case (idx)
      2'd0:    return CMD_FUNCTION_SET;
      2'd1:    return CMD_ENTRY_MODE;
      2'd2:    return CMD_DISPLAY_ON;
      default: return CMD_CLEAR;
    endcase
  endfunction

  function automatic int unsigned tmax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer_if.sv
// Byte-producer handshake into the LCD write sequencer.
interface lcd_write_sequencer_if;
  logic [7:0] iData;
  logic       iData_Ready;
  logic       oReadyForData;

  modport master (output iData, output iData_Ready, input oReadyForData);
  modport slave  (input iData, input iData_Ready, output oReadyForData);
endinterface

// File: rtl/lcd_write_sequencer_delay_counter.sv
// Loadable down-counter: a load of N (N=0 treated as 1) gives a done pulse in the Nth cycle after loading.
module lcd_delay_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done,
  output logic         busy
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load) begin
      cnt_d  = (load_val == '0) ? '0 : load_val - W'(1);
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign done = busy_q && (cnt_q == '0);
  assign busy = busy_q;

endmodule

// File: rtl/lcd_write_sequencer.sv
// 4-bit LCD write sequencer: power-on init, panel configuration, then one
// data byte per handshake, each byte sent as two strobed nibbles.
module lcd_write_sequencer
  import lcd_write_sequencer_pkg::*;
#(
  parameter int unsigned T_POWERON = DEF_T_POWERON,
  parameter int unsigned T_4100US  = DEF_T_4100US,
  parameter int unsigned T_100US   = DEF_T_100US,
  parameter int unsigned T_40US    = DEF_T_40US,
  parameter int unsigned T_1640US  = DEF_T_1640US,
  parameter int unsigned T_GAP     = DEF_T_GAP,
  parameter int unsigned T_SETUP   = DEF_T_SETUP,
  parameter int unsigned T_EN      = DEF_T_EN,
  parameter int unsigned T_HOLD    = DEF_T_HOLD
) (
  input  logic                 Clock,
  input  logic                 Reset,
  lcd_write_sequencer_if.slave host,
  output logic                 oLCD_Enabled,
  output logic                 oLCD_RegisterSelect,
  output logic                 oLCD_StrataFlashControl,
  output logic                 oLCD_ReadWrite,
  output logic [3:0]           oLCD_Data
);

  localparam int unsigned T_MAX = tmax(tmax(tmax(T_POWERON, T_4100US), tmax(T_100US, T_40US)),
                                       tmax(tmax(T_1640US, T_GAP), tmax(T_SETUP, tmax(T_EN, T_HOLD))));
  localparam int unsigned CNT_W = $clog2(T_MAX + 2);

  function automatic logic [CNT_W-1:0] ticks(input int unsigned t);
    return CNT_W'(t);
  endfunction

  function automatic logic [CNT_W-1:0] init_wait(input logic [1:0] idx);
    case (idx)
      2'd0:    return ticks(T_4100US);
      2'd1:    return ticks(T_100US);
      default: return ticks(T_40US);
    endcase
  endfunction

  state_t     state_q, state_d;
  phase_t     phase_q, phase_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] lo_nib_q, lo_nib_d;
  logic [3:0] nib_q, nib_d;
  logic       e_q, e_d, rs_q, rs_d, rdy_q, rdy_d;

  logic             load, cnt_done, cnt_busy, start_nib;
  logic [CNT_W-1:0] load_val;
  logic [3:0]       next_nib;
  logic [7:0]       cmd_cur, cmd_next;

  assign cmd_cur  = cfg_command(idx_q);
  assign cmd_next = cfg_command(idx_q + 2'd1);

  lcd_delay_counter #(.W(CNT_W)) u_delay (
    .clk(Clock), .rst(Reset), .load(load), .load_val(load_val),
    .done(cnt_done), .busy(cnt_busy)
  );

  always_comb begin
    state_d = state_q; phase_d = phase_q; idx_d = idx_q; lo_nib_d = lo_nib_q;
    nib_d = nib_q; e_d = e_q; rs_d = rs_q; rdy_d = rdy_q;
    load = 1'b0; load_val = '0; start_nib = 1'b0; next_nib = nib_q;
    unique case (state_q)
      POWERON: begin
        // The counter comes out of reset idle, so the power-on wait is armed here.
        if (!cnt_busy) begin
          load = 1'b1; load_val = ticks(T_POWERON);
        end else if (cnt_done) begin
          state_d = INIT_NIB; idx_d = 2'd0; start_nib = 1'b1; next_nib = init_nibble(2'd0);
        end
      end
      INIT_NIB, CFG_HI, CFG_LO, DATA_HI, DATA_LO: begin
        if (cnt_done) begin
          load = 1'b1;
          case (phase_q)
            PH_SETUP: begin phase_d = PH_EN;   e_d = 1'b1; load_val = ticks(T_EN);   end
            PH_EN:    begin phase_d = PH_HOLD; e_d = 1'b0; load_val = ticks(T_HOLD); end
            default: begin
              case (state_q)
                INIT_NIB: begin state_d = INIT_WAIT; load_val = init_wait(idx_q); end
                CFG_HI:   begin state_d = CFG_GAP;   load_val = ticks(T_GAP);     end
                CFG_LO:   begin
                  state_d  = CFG_WAIT;
                  load_val = (idx_q == 2'd3) ? ticks(T_1640US) : ticks(T_40US);
                end
                DATA_HI:  begin state_d = DATA_GAP;  load_val = ticks(T_GAP);     end
                default:  begin state_d = DATA_WAIT; load_val = ticks(T_40US);    end
              endcase
            end
          endcase
        end
      end
      INIT_WAIT: if (cnt_done) begin
        start_nib = 1'b1;
        if (idx_q == 2'd3) begin
          state_d = CFG_HI; idx_d = 2'd0; next_nib = cmd_next[7:4];
        end else begin
          state_d = INIT_NIB; idx_d = idx_q + 2'd1; next_nib = init_nibble(idx_q + 2'd1);
        end
      end
      CFG_GAP: if (cnt_done) begin
        state_d = CFG_LO; start_nib = 1'b1; next_nib = cmd_cur[3:0];
      end
      CFG_WAIT: if (cnt_done) begin
        if (idx_q == 2'd3) begin
          state_d = IDLE; rdy_d = 1'b1;
        end else begin
          state_d = CFG_HI; idx_d = idx_q + 2'd1; start_nib = 1'b1; next_nib = cmd_next[7:4];
        end
      end
      IDLE: if (host.iData_Ready) begin
        // Upper nibble goes straight out; only the lower one needs to survive the gap.
        state_d = DATA_HI; rdy_d = 1'b0; rs_d = 1'b1; lo_nib_d = host.iData[3:0];
        start_nib = 1'b1; next_nib = host.iData[7:4];
      end
      DATA_GAP: if (cnt_done) begin
        state_d = DATA_LO; start_nib = 1'b1; next_nib = lo_nib_q;
      end
      DATA_WAIT: if (cnt_done) begin
        state_d = IDLE; rdy_d = 1'b1;
      end
      default: state_d = POWERON;
    endcase
    if (start_nib) begin
      phase_d = PH_SETUP; e_d = 1'b0; nib_d = next_nib;
      load = 1'b1; load_val = ticks(T_SETUP);
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= POWERON;
      phase_q <= PH_SETUP;
      idx_q   <= 2'd0;
      nib_q   <= 4'h0;
      e_q     <= 1'b0;
      rs_q    <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      nib_q   <= nib_d;
      e_q     <= e_d;
      rs_q    <= rs_d;
      rdy_q   <= rdy_d;
    end
  end

  always_ff @(posedge Clock) lo_nib_q <= lo_nib_d;

  assign oLCD_Enabled            = e_q;
  assign oLCD_RegisterSelect     = rs_q;
  assign oLCD_Data               = nib_q;
  assign oLCD_StrataFlashControl = 1'b1;
  assign oLCD_ReadWrite          = 1'b0;
  assign host.oReadyForData      = rdy_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Randomized bench for lcd_write_sequencer against a strobe-level reference model.
module tb_lcd_write_sequencer;

  localparam int P_POWERON = 20, P_4100 = 8, P_100 = 6, P_40 = 4, P_1640 = 10;
  localparam int P_GAP = 3, P_SETUP = 2, P_EN = 3, P_HOLD = 1;
  localparam int NIB     = P_SETUP + P_EN + P_HOLD;
  localparam int ACC_GAP = 2 * NIB + P_GAP + P_40 + 1;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_StrataFlashControl, oLCD_ReadWrite;
  logic [3:0] oLCD_Data;

  lcd_write_sequencer_if host();

  lcd_write_sequencer #(
    .T_POWERON(P_POWERON), .T_4100US(P_4100), .T_100US(P_100), .T_40US(P_40),
    .T_1640US(P_1640), .T_GAP(P_GAP), .T_SETUP(P_SETUP), .T_EN(P_EN), .T_HOLD(P_HOLD)
  ) dut (
    .Clock(Clock), .Reset(Reset), .host(host),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_StrataFlashControl(oLCD_StrataFlashControl), .oLCD_ReadWrite(oLCD_ReadWrite),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int checks   = 0;
  int failures = 0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: expected strobe stream as {rs, nibble}, plus accept log.
  int exp_q[$];
  int acc_t[$];
  int acc_count = 0;
  int cyc = 0;
  int init_seq[12] = '{3, 3, 3, 2, 2, 8, 0, 6, 0, 12, 0, 1};

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic push_init();
    exp_q.delete();
    foreach (init_seq[i]) exp_q.push_back(init_seq[i]);
  endtask

  initial begin : monitor
    bit         e_prev = 1'b0;
    bit         rst_seen = 1'b0;
    int         width = 0;
    int         stable = 0;
    logic [3:0] cur_nib = 4'h0;
    logic [3:0] prev_data = 4'h0;
    forever begin
      @(negedge Clock);
      chk_eq("sf_const", oLCD_StrataFlashControl, 1);
      chk_eq("rw_const", oLCD_ReadWrite, 0);
      if (host.oReadyForData === 1'b1 && host.iData_Ready === 1'b1) begin
        acc_count++;
        acc_t.push_back(cyc);
        exp_q.push_back(16 + int'(host.iData[7:4]));
        exp_q.push_back(16 + int'(host.iData[3:0]));
      end
      if (oLCD_Enabled === 1'b1) begin
        if (!e_prev) begin
          chk_eq("setup_len", stable >= P_SETUP, 1);
          chk_eq("strobe_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk_eq("strobe_rs_nib", {oLCD_RegisterSelect, oLCD_Data}, exp_q.pop_front());
          cur_nib  = oLCD_Data;
          width    = 1;
          rst_seen = Reset;
        end else begin
          width++;
          chk_eq("en_nib", oLCD_Data, cur_nib);
        end
        stable = 0;
      end else begin
        if (e_prev && !rst_seen) begin
          chk_eq("e_width", width, P_EN);
          chk_eq("hold_nib", oLCD_Data, cur_nib);
        end
        stable = (stable > 0 && oLCD_Data == prev_data) ? stable + 1 : 1;
      end
      if (Reset) rst_seen = 1'b1;
      e_prev    = (oLCD_Enabled === 1'b1);
      prev_data = oLCD_Data;
    end
  end

  // Returns at posedge+1 once oReadyForData is high; optionally pokes iData_Ready while busy.
  task automatic wait_ready(input int max_cyc, input bit poke, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge Clock); #1;
      if (host.oReadyForData) begin
        host.iData_Ready = 1'b0;
        ok = 1'b1;
        break;
      end
      if (poke) begin
        host.iData_Ready = 1'($urandom_range(0, 1));
        host.iData       = 8'($urandom);
      end
    end
    host.iData_Ready = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stimulus
    bit         ok;
    bit         found;
    int         base;
    logic [7:0] b;
    logic       e_exp, in_hi, in_lo;
    int         lo0;

    host.iData = 8'h00;
    host.iData_Ready = 1'b0;

    // Reset state
    repeat (3) @(negedge Clock);
    chk_eq("rst_e", oLCD_Enabled, 0);
    chk_eq("rst_rs", oLCD_RegisterSelect, 0);
    chk_eq("rst_data", oLCD_Data, 0);
    chk_eq("rst_rdy", host.oReadyForData, 0);
    chk_eq("rst_sf", oLCD_StrataFlashControl, 1);
    chk_eq("rst_rw", oLCD_ReadWrite, 0);

    // Init sequence, with iData_Ready poked while busy
    push_init();
    @(posedge Clock); #1;
    Reset = 1'b0;
    wait_ready(1000, 1'b1, ok);
    chk_eq("init_ready", ok, 1);
    chk_eq("init_strobes_left", exp_q.size(), 0);
    chk_eq("busy_accepts", acc_count, 0);

    // Single byte with cycle-exact trace
    b = 8'h41;
    host.iData = b;
    host.iData_Ready = 1'b1;
    @(posedge Clock); #1;
    host.iData_Ready = 1'b0;
    host.iData = 8'($urandom);
    lo0 = NIB + P_GAP;
    for (int k = 1; k <= ACC_GAP; k++) begin
      @(negedge Clock);
      in_hi = (k >= 1 && k <= NIB);
      in_lo = (k > lo0 && k <= lo0 + NIB);
      e_exp = (k > P_SETUP && k <= P_SETUP + P_EN) ||
              (k > lo0 + P_SETUP && k <= lo0 + P_SETUP + P_EN);
      chk_eq("s2_e", oLCD_Enabled, e_exp);
      chk_eq("s2_rdy", host.oReadyForData, k == ACC_GAP);
      if (in_hi) chk_eq("s2_hi", oLCD_Data, b[7:4]);
      if (in_lo) chk_eq("s2_lo", oLCD_Data, b[3:0]);
      if (in_hi || in_lo) chk_eq("s2_rs", oLCD_RegisterSelect, 1);
    end
    chk_eq("s2_accepts", acc_count, 1);

    // Back-to-back bytes with iData changing every cycle
    acc_t.delete();
    base = acc_count;
    for (int i = 0; i < 120; i++) begin
      @(posedge Clock); #1;
      host.iData = 8'($urandom);
      host.iData_Ready = 1'b1;
    end
    host.iData_Ready = 1'b0;
    chk_eq("s3_accepts", (acc_count - base) >= 5, 1);
    for (int i = 1; i < acc_t.size(); i++)
      chk_eq("s3_interval", acc_t[i] - acc_t[i-1], ACC_GAP);
    wait_ready(100, 1'b0, ok);
    chk_eq("s3_ready", ok, 1);
    chk_eq("s3_drain", exp_q.size(), 0);

    // Reset during E-high of a data nibble
    host.iData = 8'($urandom);
    host.iData_Ready = 1'b1;
    @(posedge Clock); #1;
    host.iData_Ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (oLCD_Enabled && oLCD_RegisterSelect) begin
        found = 1'b1;
        break;
      end
      @(posedge Clock); #1;
    end
    chk_eq("s5_data_e_high", found, 1);
    Reset = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    chk_eq("s5_e", oLCD_Enabled, 0);
    chk_eq("s5_rs", oLCD_RegisterSelect, 0);
    chk_eq("s5_data", oLCD_Data, 0);
    chk_eq("s5_rdy", host.oReadyForData, 0);
    @(posedge Clock); #1;
    push_init();
    base = acc_count;
    @(posedge Clock); #1;
    Reset = 1'b0;
    wait_ready(1000, 1'b1, ok);
    chk_eq("s5_reinit_ready", ok, 1);
    chk_eq("s5_reinit_strobes_left", exp_q.size(), 0);
    chk_eq("s5_busy_accepts", acc_count - base, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
